// File: rtl/sbs_pkg.sv
// Shared definitions for the serial borrow-chain subtractor: FSM states,
// borrow-cell classes and the supported digit widths.
package sbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BC_KILL = 2'd0,
    BC_PROP = 2'd1,
    BC_GEN  = 2'd2
  } bclass_t;

  localparam int DIGIT_1 = 1;
  localparam int DIGIT_2 = 2;
  localparam int DIGIT_4 = 4;

  // Classify one bit position of x - y by how it treats the incoming borrow.
  function automatic bclass_t classify(input logic xb, input logic yb);
    if (xb == yb) begin
      return BC_PROP;
    end else if (yb) begin
      return BC_GEN;
    end else begin
      return BC_KILL;
    end
  endfunction

  function automatic logic digit_legal(input int d);
    return (d == DIGIT_1) || (d == DIGIT_2) || (d == DIGIT_4);
  endfunction

endpackage

// File: rtl/serial_borrow_subtractor_borrow_cell.sv
// One-bit kill/propagate/generate borrow cell for x - y - b.
module borrow_cell
  import sbs_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic b,
  output logic d,
  output logic b_out
);

  bclass_t cls;

  assign cls = classify(x, y);
  assign d   = (x ^ y) ^ b;

  // Borrow out is forced by generate/kill, otherwise the incoming borrow passes.
  always_comb begin
    b_out = b;
    unique case (cls)
      BC_GEN:  b_out = 1'b1;
      BC_KILL: b_out = 1'b0;
      default: b_out = b;
    endcase
  end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle subtractor diff = x - y - borrow_in, DIGIT bits per clock over a
// ripple borrow chain, with valid/ready on both sides.
// Optional feature macro: SBS_OVERFLOW_EN adds the two's-complement overflow output.
module serial_borrow_subtractor
  import sbs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
`ifdef SBS_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!digit_legal(DIGIT) || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_borrow_subtractor: DIGIT must be 1, 2 or 4 and divide WIDTH");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic             b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;

  // The operand registers shift right one digit per clock, so the digit under
  // resolution always sits in the low DIGIT bits.
  logic [DIGIT-1:0] cd;
  logic [DIGIT:0]   cb;

  assign cb[0] = b_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    borrow_cell u_cell (
      .x    (xs_q[i]),
      .y    (ys_q[i]),
      .b    (cb[i]),
      .d    (cd[i]),
      .b_out(cb[i+1])
    );
  end

`ifdef SBS_OVERFLOW_EN
  // Sign bits are kept separately because the shifting operands lose them.
  logic xm_q, xm_d;
  logic ym_q, ym_d;
  logic ovf_q, ovf_d;
`endif

  // Next-state, operand capture and per-digit result write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SBS_OVERFLOW_EN
    xm_d    = xm_q;
    ym_d    = ym_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          xs_d    = x;
          ys_d    = y;
          b_d     = borrow_in;
          diff_d  = '0;
          bo_d    = 1'b0;
`ifdef SBS_OVERFLOW_EN
          xm_d    = x[WIDTH-1];
          ym_d    = y[WIDTH-1];
          ovf_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        xs_d  = xs_q >> DIGIT;
        ys_d  = ys_q >> DIGIT;
        b_d   = cb[DIGIT];
        cnt_d = cnt_q + CNT_W'(1);
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            diff_d[k*DIGIT +: DIGIT] = cd;
          end
        end
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          bo_d    = cb[DIGIT];
`ifdef SBS_OVERFLOW_EN
          ovf_d   = (xm_q ^ ym_q) & (xm_q ^ cd[DIGIT-1]);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns every output to its idle value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      b_q     <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SBS_OVERFLOW_EN
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
`ifdef SBS_OVERFLOW_EN
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
`ifdef SBS_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor: an 8-bit/1-bit-digit instance checked
// every cycle against an arithmetic model, plus an 8-bit/4-bit-digit instance
// for latency and throughput.
module tb_serial_borrow_subtractor;

  localparam int N1 = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] x, y, diff;
  logic       bin, borrow_out;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [7:0] x4, y4, diff4;
  logic       bin4, borrow_out4;

`ifdef SBS_OVERFLOW_EN
  logic       ovf, ovf4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_borrow_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .borrow_in (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .busy      (busy)
`ifdef SBS_OVERFLOW_EN
    ,
    .overflow  (ovf)
`endif
  );

  serial_borrow_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .x         (x4),
    .y         (y4),
    .borrow_in (bin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .diff      (diff4),
    .borrow_out(borrow_out4),
    .busy      (busy4)
`ifdef SBS_OVERFLOW_EN
    ,
    .overflow  (ovf4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a pending operation, its acceptance edge and its arithmetic result.
  bit         m_pend = 1'b0;
  int         m_acc  = 0;
  logic [7:0] m_diff;
  logic       m_bo;
  logic       m_ovf;

  always @(negedge clk) begin
    bit         exp_ov;
    int         r;
    logic [7:0] mask;
    if (rst) begin
      m_pend = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow_out", borrow_out, 0);
`ifdef SBS_OVERFLOW_EN
      chk("rst_overflow", ovf, 0);
`endif
    end else begin
      exp_ov = m_pend && (cyc >= m_acc + N1);
      chk("in_ready", in_ready, !m_pend);
      chk("busy", busy, m_pend);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("diff", diff, m_diff);
        chk("borrow_out", borrow_out, m_bo);
`ifdef SBS_OVERFLOW_EN
        chk("overflow", ovf, m_ovf);
`endif
      end else if (m_pend) begin
        r    = cyc - m_acc;
        mask = 8'((32'd1 << r) - 1);
        chk("diff_partial", diff, m_diff & mask);
      end
      if (!m_pend && in_valid) begin
        m_pend = 1'b1;
        m_acc  = cyc + 1;
        m_diff = x - y - 8'(bin);
        m_bo   = (int'(x) < int'(y) + int'(bin));
        m_ovf  = (x[7] ^ y[7]) & (x[7] ^ m_diff[7]);
      end else if (exp_ov && out_ready) begin
        m_pend = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input string nm);
    int lat;
    @(posedge clk); #1;
    x = a; y = b; bin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_borrow"}, borrow_out, eb);
`ifdef SBS_OVERFLOW_EN
    chk({nm, "_overflow"}, ovf, eo);
`else
    if (eo === 1'bx) chk({nm, "_unused"}, 0, 1);
`endif
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         w;
    int         accs[$];
    int         first_ov;
    int         pulses;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; bin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; x4 = '0; y4 = '0; bin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_in_ready", in_ready, 1);
    chk("init_diff", diff, 0);
    chk("init_out_valid4", out_valid4, 0);
    rst = 1'b0;

    run_op(8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 1'b0, "v5A_33");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "v00_01");
    run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "v10_0F_b");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "v80_01");
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "v05_03");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "vFF_FF_b");

    // Consumer stall: result held, new operands ignored.
    out_ready = 1'b0;
    @(posedge clk); #1;
    x = 8'hC3; y = 8'h3C; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("stall_first_diff", diff, 8'h87);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      x = 8'h11; y = 8'h22; in_valid = 1'b1;
      chk("stall_diff", diff, 8'h87);
      chk("stall_borrow", borrow_out, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("release_no_accept", busy, 0);

    // Reset in the middle of RUN while digit 3 is pending.
    x = 8'hF0; y = 8'h0F; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(8'h37, 8'h12, 1'b0, 8'h25, 1'b0, 1'b0, "post_rst");

    // Four bits per clock: latency 2, back-to-back period 4.
    @(posedge clk); #1;
    x4 = 8'hA0; y4 = 8'h0B; bin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
    first_ov = -1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (in_ready4) accs.push_back(cyc + 1);
      if (out_valid4) begin
        pulses++;
        if (first_ov < 0) first_ov = cyc;
        chk("d4_diff", diff4, 8'h95);
        chk("d4_borrow", borrow_out4, 0);
      end
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    chk("d4_accepts", (accs.size() >= 3) ? 1 : 0, 1);
    if (accs.size() >= 3) begin
      chk("d4_latency", first_ov - accs[0], 2);
      chk("d4_period_a", accs[1] - accs[0], 4);
      chk("d4_period_b", accs[2] - accs[1], 4);
    end
    chk("d4_pulses_seen", (pulses >= 3) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Multi-cycle unsigned/two's-complement subtractor computing `diff = x - y - borrow_in`, a few bits per clock, over a ripple borrow chain. Each bit is resolved by a kill/propagate/generate borrow cell, so this block is the subtracting counterpart of the 4-bit carry-chain adder. It sits beside the adders in the arithmetic library. Operands enter and results leave through valid/ready handshakes, so it can be dropped between registered datapath stages.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be a multiple of `DIGIT`.
- `DIGIT`, default 1: bits resolved per clock. Legal values are 1, 2 and 4.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `in_valid` input, 1 bit: operands are presented.
- `in_ready` output, 1 bit: block accepts operands.
- `x`, `y` input, `WIDTH` bits: minuend and subtrahend.
- `borrow_in` input, 1 bit: initial borrow.
- `out_valid` output, 1 bit: result is presented.
- `out_ready` input, 1 bit: consumer accepts the result.
- `diff` output, `WIDTH` bits: result, modulo 2^WIDTH.
- `borrow_out` output, 1 bit: 1 iff unsigned `x < y + borrow_in`.
- `busy` output, 1 bit: high in RUN or DONE.
- `overflow` output, 1 bit: two's-complement overflow. Present only with `SBS_OVERFLOW_EN`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`, capture `x`, `y` and `borrow_in`, clear the digit counter, go to RUN.
- **RUN:**
  - Each clock resolves digit `k` (bits `k*DIGIT` .. `k*DIGIT+DIGIT-1`) using the registered borrow.
  - Writes those `diff` bits and updates the borrow register.
  - After digit `N-1` (N = WIDTH/DIGIT), go to DONE.
- **Borrow cell, per bit (`b` = incoming borrow):**
  - `p = x^y`.
  - Generate when `x=0, y=1`: borrow=1.
  - Kill when `x=1, y=0`: borrow=0.
  - Propagate when `x==y`: borrow=`b`.
  - `d = p ^ b`.
- **DONE:**
  - `out_valid`=1. `diff`, `borrow_out` and `overflow` are held stable.
  - On `out_ready`, go to IDLE.
- Input pins are ignored outside IDLE; captured operands are unaffected by pin changes.
- **Overflow:** `(x[W-1]^y[W-1]) & (x[W-1]^diff[W-1])`, using captured operands. Valid only while `out_valid`=1.

## Timing
- **Reset values:**
  - State IDLE.
  - `in_ready`=1.
  - `out_valid`=0, `busy`=0.
  - `diff`=0, `borrow_out`=0, `overflow`=0.
- Acceptance edge is E0. RUN occupies edges E1..EN. `out_valid` is high after EN, i.e. N cycles after acceptance.
- `in_ready`=0 in the cycle after acceptance and throughout RUN and DONE.
- With `out_ready` tied high, the result handshake occurs at edge E(N+1), and the next acceptance is possible at E(N+2). Minimum period is N+2 cycles.
- No acceptance is allowed in the same cycle as the result handshake.
- `out_ready` low: DONE is held indefinitely and outputs do not change.
- `rst` asserted in any state, including mid-RUN: returns to reset values immediately. The partial result is discarded and no `out_valid` pulse is produced.
- `diff` bits not yet resolved read 0 during RUN. Consumers use `diff` only while `out_valid`=1.

## Configuration
- Macro: `SBS_OVERFLOW_EN`.
- **Defined:** the `overflow` port and its register exist and follow the rule above.
- **Undefined:**
  - The port and its logic are absent.
  - `diff`, `borrow_out` and timing are identical to the defined case.

## Structure
- **Shared package `sbs_pkg`:**
  - State enum typedef (IDLE/RUN/DONE).
  - Borrow-cell class encoding (KILL/PROP/GEN).
  - Legal `DIGIT` constants.
- **Sub-module `borrow_cell`:**
  - Combinational, one bit: inputs `x`, `y`, `b`; outputs `d`, `b_out`.
  - Instantiated `DIGIT` times in a ripple chain for the per-clock slice.
- Top level holds the FSM, digit counter, operand/result registers and the borrow register.

## Test plan
- WIDTH=8, DIGIT=1: `x`=0x5A, `y`=0x33, `borrow_in`=0 → `diff`=0x27, `borrow_out`=0, `out_valid` 8 cycles after acceptance.
- `x`=0x00, `y`=0x01, `borrow_in`=0 → `diff`=0xFF, `borrow_out`=1. Also `x`=0x10, `y`=0x0F, `borrow_in`=1 → `diff`=0x00, `borrow_out`=0.
- `SBS_OVERFLOW_EN`: `x`=0x80, `y`=0x01 → `diff`=0x7F, `overflow`=1. Also `x`=0x05, `y`=0x03 → `overflow`=0.
- `out_ready` low for 5 cycles in DONE → `diff` and `borrow_out` stable, `in_ready`=0, a new `in_valid` is ignored. Release → one handshake, then IDLE.
- Assert `rst` at RUN digit 3 → all outputs at reset values immediately. A new operation after release completes correctly.
- WIDTH=8, DIGIT=4: `x`=0xA0, `y`=0x0B → `diff`=0x95, `borrow_out`=0, `out_valid` 2 cycles after acceptance. Also check back-to-back period = 4 cycles.
